branch_predictor: RTL and testbench

- IF-stage direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Predicts taken/target for the fetch PC one cycle after lookup.
- Trained by the EX-stage branch resolution result.
- Detects mispredictions and issues a registered fetch redirect, honouring the MIPS delay slot (fall-through is PC+8).

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/bp_sat_counter.sv | 28 ++
 rtl/branch_predictor.sv | 149 ++++++++++++++
 tb/tb_branch_predictor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: BTB entry layout, direction-counter encoding and the
// MIPS delay-slot fall-through offset used by the branch predictor.
package cpu_pkg;

    localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;
    localparam int          BTB_TAG_MAX_W     = 30;
    localparam int          BTB_TGT_W         = 30;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Tag field is sized for the widest legal TAG_W; narrower tables leave the top bits zero.
    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_MAX_W-1:0] tag;
        logic [BTB_TGT_W-1:0]     target;
        ctr_e                     ctr;
    } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state for a 2-bit saturating branch-direction counter.
module bp_sat_counter
    import cpu_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_taken,
    input  logic i_force_strong,
    output ctr_e o_ctr
);

    logic [1:0] w_inc;
    logic [1:0] w_dec;

    assign w_inc = i_ctr + 2'd1;
    assign w_dec = i_ctr - 2'd1;

    always_comb begin
        o_ctr = i_ctr;
        if (i_force_strong) begin
            o_ctr = CTR_ST;
        end else if (i_taken) begin
            if (i_ctr != CTR_ST) o_ctr = ctr_e'(w_inc);
        end else begin
            if (i_ctr != CTR_SNT) o_ctr = ctr_e'(w_dec);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: one-cycle lookup for IF,
// training from EX resolution, and a registered misprediction redirect.
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_valid,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_uncond,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int ENTRIES = 2 ** INDEX_W;
    localparam int TAG_LO  = INDEX_W + 2;
    localparam int TAG_HI  = INDEX_W + TAG_W + 1;

    logic [ENTRIES-1:0]   r_valid;
    logic [TAG_W-1:0]     r_tag    [ENTRIES];
    logic [BTB_TGT_W-1:0] r_target [ENTRIES];
    ctr_e                 r_ctr    [ENTRIES];

    logic                 r_pred_valid;
    logic                 r_pred_hit;
    logic                 r_pred_taken;
    logic [31:0]          r_pred_target;
    logic                 r_redirect_valid;
    logic [31:0]          r_redirect_pc;

    logic [INDEX_W-1:0]   w_lk_idx;
    logic [TAG_W-1:0]     w_lk_tag;
    btb_entry_t           w_lk_entry;
    logic                 w_lk_hit;

    logic [INDEX_W-1:0]   w_upd_idx;
    logic [TAG_W-1:0]     w_upd_tag;
    logic                 w_upd_hit;
    ctr_e                 w_ctr_seed;
    ctr_e                 w_ctr_next;
    logic                 w_alloc;
    logic                 w_wr_ctr;
    logic                 w_wr_tgt;
    logic                 w_mispredict;
    logic [31:0]          w_correct_pc;
    logic                 w_unused;

    assign w_unused = &{1'b0, if_pc[31:TAG_HI+1], if_pc[1:0], upd_pc[31:TAG_HI+1]};

    // Lookup path: reads the arrays before any same-edge update lands.
    assign w_lk_idx = if_pc[INDEX_W+1:2];
    assign w_lk_tag = if_pc[TAG_HI:TAG_LO];

    always_comb begin
        w_lk_entry        = '0;
        w_lk_entry.valid  = r_valid[w_lk_idx];
        w_lk_entry.tag    = BTB_TAG_MAX_W'(r_tag[w_lk_idx]);
        w_lk_entry.target = r_target[w_lk_idx];
        w_lk_entry.ctr    = r_ctr[w_lk_idx];
    end

    assign w_lk_hit = w_lk_entry.valid && (w_lk_entry.tag == BTB_TAG_MAX_W'(w_lk_tag));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_valid  <= 1'b0;
            r_pred_hit    <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else begin
            r_pred_valid <= if_valid;
            if (if_valid) begin
                r_pred_hit    <= w_lk_hit;
                r_pred_taken  <= w_lk_hit && w_lk_entry.ctr[1];
                r_pred_target <= w_lk_hit ? {w_lk_entry.target, 2'b00} : '0;
            end
        end
    end

    // Training path
    assign w_upd_idx = upd_pc[INDEX_W+1:2];
    assign w_upd_tag = upd_pc[TAG_HI:TAG_LO];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    // A fresh allocation starts from weak-NT so one taken step lands on weak-T.
    assign w_ctr_seed = w_upd_hit ? r_ctr[w_upd_idx] : CTR_WNT;

    bp_sat_counter u_ctr (
        .i_ctr          (w_ctr_seed),
        .i_taken        (upd_taken),
        .i_force_strong (upd_uncond),
        .o_ctr          (w_ctr_next)
    );

    assign w_alloc  = upd_en && !w_upd_hit && upd_taken;
    assign w_wr_ctr = upd_en && (w_upd_hit || upd_taken);
    assign w_wr_tgt = upd_en && (upd_taken || (w_upd_hit && upd_uncond));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_alloc) begin
            r_valid[w_upd_idx] <= 1'b1;
        end
    end

    // Payload fields need no reset: the cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (w_alloc)  r_tag[w_upd_idx]    <= w_upd_tag;
        if (w_wr_tgt) r_target[w_upd_idx] <= upd_target[31:2];
        if (w_wr_ctr) r_ctr[w_upd_idx]    <= w_ctr_next;
    end

    // Redirect path
    assign w_mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && (upd_target != upd_pred_target)));
    assign w_correct_pc = upd_taken ? upd_target : (upd_pc + DELAY_SLOT_OFFSET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) r_redirect_pc <= w_correct_pc;
        end
    end

    assign pred_valid     = r_pred_valid;
    assign pred_hit       = r_pred_hit;
    assign pred_taken     = r_pred_taken;
    assign pred_target    = r_pred_target;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, async-reset sequence, and
// random traffic scored against an array-based reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_valid, pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_en, upd_uncond, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_W(6), .TAG_W(10)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .pred_valid      (pred_valid),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_en          (upd_en),
        .upd_pc          (upd_pc),
        .upd_uncond      (upd_uncond),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        ue;
        logic [31:0] upc;
        logic        uu, ut;
        logic [31:0] utg;
        logic        upt;
        logic [31:0] uptg;
        logic        pv, ph, pt;
        logic [31:0] ptg;
        logic        rv;
        logic [31:0] rpc;
    } vec_t;

    function automatic vec_t mk(input logic lv, input logic [31:0] lpc, input logic ue,
                                input logic [31:0] upc, input logic uu, input logic ut,
                                input logic [31:0] utg, input logic upt, input logic [31:0] uptg,
                                input logic pv, input logic ph, input logic pt,
                                input logic [31:0] ptg, input logic rv, input logic [31:0] rpc);
        vec_t v;
        v.lv = lv; v.lpc = lpc; v.ue = ue; v.upc = upc; v.uu = uu; v.ut = ut;
        v.utg = utg; v.upt = upt; v.uptg = uptg;
        v.pv = pv; v.ph = ph; v.pt = pt; v.ptg = ptg; v.rv = rv; v.rpc = rpc;
        return v;
    endfunction

    task automatic drive(input logic lv, input logic [31:0] lpc, input logic ue,
                         input logic [31:0] upc, input logic uu, input logic ut,
                         input logic [31:0] utg, input logic upt, input logic [31:0] uptg);
        if_valid = lv; if_pc = lpc;
        upd_en = ue; upd_pc = upc; upd_uncond = uu; upd_taken = ut;
        upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain arrays indexed by the BTB slot, counter as an integer 0..3.
    bit          m_v   [64];
    int          m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ctr [64];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h3F);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 8) & 32'h3FF);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'h0; m_ctr[i] = 0;
        end
    endtask

    task automatic m_lookup(input logic [31:0] pc, output logic hit, output logic tk,
                            output logic [31:0] tgt);
        int i;
        i   = idx_of(pc);
        hit = m_v[i] && (m_tag[i] == tag_of(pc));
        tk  = hit && (m_ctr[i] >= 2);
        tgt = hit ? m_tgt[i] : 32'h0;
    endtask

    task automatic m_update(input logic [31:0] pc, input logic uu, input logic ut,
                            input logic [31:0] tg);
        int  i;
        bit  hit;
        i   = idx_of(pc);
        hit = m_v[i] && (m_tag[i] == tag_of(pc));
        if (hit) begin
            if (uu) begin
                m_ctr[i] = 3; m_tgt[i] = tg;
            end else if (ut) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = tg;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (ut) begin
            m_v[i] = 1'b1; m_tag[i] = tag_of(pc); m_tgt[i] = tg;
            m_ctr[i] = uu ? 3 : 2;
        end
    endtask

    vec_t vt[$];

    initial begin
        logic        e_ph, e_pt, e_rv, hit, tk;
        logic [31:0] e_ptg, e_rpc, tg, r0, r1;
        logic        lv, ue, uu, ut, upt;
        logic [31:0] lpc, upc, utg, uptg;

        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pred_valid", {31'h0, pred_valid}, 32'h0);
        chk("reset_pred_hit", {31'h0, pred_hit}, 32'h0);
        chk("reset_pred_taken", {31'h0, pred_taken}, 32'h0);
        chk("reset_pred_target", pred_target, 32'h0);
        chk("reset_redirect_valid", {31'h0, redirect_valid}, 32'h0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        rst_n = 1'b1;
        tick();

        vt.push_back(mk(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0,                              1, 0, 0, 32'h0, 0, 0));
        vt.push_back(mk(0, 0, 1, 32'h00400010, 0, 1, 32'h00400100, 0, 0,                   0, 0, 0, 32'h0, 1, 32'h00400100));
        vt.push_back(mk(1, 32'h00400010, 0, 0, 0, 0, 0, 0, 0,                              1, 1, 1, 32'h00400100, 0, 0));
        vt.push_back(mk(0, 0, 1, 32'h00400010, 0, 0, 32'h00400100, 1, 32'h00400100,        0, 1, 1, 32'h00400100, 1, 32'h00400018));
        vt.push_back(mk(0, 0, 1, 32'h00400010, 0, 0, 32'h00400100, 1, 32'h00400100,        0, 1, 1, 32'h00400100, 1, 32'h00400018));
        vt.push_back(mk(1, 32'h00400010, 0, 0, 0, 0, 0, 0, 0,                              1, 1, 0, 32'h00400100, 0, 0));
        vt.push_back(mk(0, 0, 1, 32'h00401010, 0, 1, 32'h00402000, 0, 0,                   0, 1, 0, 32'h00400100, 1, 32'h00402000));
        vt.push_back(mk(1, 32'h00400010, 0, 0, 0, 0, 0, 0, 0,                              1, 0, 0, 32'h0, 0, 0));
        vt.push_back(mk(1, 32'h00401010, 0, 0, 0, 0, 0, 0, 0,                              1, 1, 1, 32'h00402000, 0, 0));
        vt.push_back(mk(1, 32'h00400020, 1, 32'h00400020, 1, 1, 32'h00400800, 1, 32'h00400800, 1, 0, 0, 32'h0, 0, 0));
        vt.push_back(mk(1, 32'h00400020, 0, 0, 0, 0, 0, 0, 0,                              1, 1, 1, 32'h00400800, 0, 0));
        vt.push_back(mk(1, 32'h00400020, 1, 32'h00400020, 1, 1, 32'h00400900, 1, 32'h00400800, 1, 1, 1, 32'h00400800, 1, 32'h00400900));
        vt.push_back(mk(1, 32'h00400020, 0, 0, 0, 0, 0, 0, 0,                              1, 1, 1, 32'h00400900, 0, 0));
        vt.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0, 1, 32'h0,                      0, 1, 1, 32'h00400900, 1, 32'h00000004));
        vt.push_back(mk(0, 0, 1, 32'h00401010, 0, 1, 32'h00402000, 1, 32'h00402000,        0, 1, 1, 32'h00400900, 0, 0));
        vt.push_back(mk(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0,                              1, 0, 0, 32'h0, 0, 0));

        foreach (vt[k]) begin
            drive(vt[k].lv, vt[k].lpc, vt[k].ue, vt[k].upc, vt[k].uu, vt[k].ut,
                  vt[k].utg, vt[k].upt, vt[k].uptg);
            tick();
            chk($sformatf("vec%0d_pred_valid", k), {31'h0, pred_valid}, {31'h0, vt[k].pv});
            chk($sformatf("vec%0d_pred_hit", k), {31'h0, pred_hit}, {31'h0, vt[k].ph});
            chk($sformatf("vec%0d_pred_taken", k), {31'h0, pred_taken}, {31'h0, vt[k].pt});
            chk($sformatf("vec%0d_pred_target", k), pred_target, vt[k].ptg);
            chk($sformatf("vec%0d_redirect_valid", k), {31'h0, redirect_valid}, {31'h0, vt[k].rv});
            if (vt[k].rv) chk($sformatf("vec%0d_redirect_pc", k), redirect_pc, vt[k].rpc);
        end

        // Async reset pulse while a redirect is live and a hit is displayed.
        drive(1, 32'h00401010, 1, 32'h00400010, 0, 1, 32'h00400100, 0, 32'h0);
        tick();
        idle();
        chk("prerst_redirect_valid", {31'h0, redirect_valid}, 32'h1);
        chk("prerst_pred_hit", {31'h0, pred_hit}, 32'h1);
        chk("prerst_pred_target", pred_target, 32'h00402000);
        #2 rst_n = 1'b0;
        #1;
        chk("asyncrst_pred_valid", {31'h0, pred_valid}, 32'h0);
        chk("asyncrst_pred_hit", {31'h0, pred_hit}, 32'h0);
        chk("asyncrst_pred_taken", {31'h0, pred_taken}, 32'h0);
        chk("asyncrst_pred_target", pred_target, 32'h0);
        chk("asyncrst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
        chk("asyncrst_redirect_pc", redirect_pc, 32'h0);
        #4 rst_n = 1'b1;
        tick();
        chk("postrst_pred_valid", {31'h0, pred_valid}, 32'h0);
        chk("postrst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
        drive(1, 32'h00401010, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("postrst_lookup1_hit", {31'h0, pred_hit}, 32'h0);
        drive(1, 32'h00400010, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("postrst_lookup2_hit", {31'h0, pred_hit}, 32'h0);
        chk("postrst_lookup2_valid", {31'h0, pred_valid}, 32'h1);

        // Random traffic against the reference model.
        m_clear();
        e_ph = 1'b0; e_pt = 1'b0; e_ptg = 32'h0;
        for (int n = 0; n < 2000; n++) begin
            lv  = ($urandom % 2) == 0;
            lpc = 32'h00400000 + ($urandom_range(0, 2) << 8) + ($urandom_range(0, 3) << 2);
            ue  = ($urandom % 3) != 0;
            upc = 32'h00400000 + ($urandom_range(0, 2) << 8) + ($urandom_range(0, 3) << 2);
            uu  = ($urandom % 5) == 0;
            ut  = uu ? 1'b1 : 1'(($urandom % 2) == 0);
            r0  = $urandom;
            utg = (($urandom % 2) == 0) ? (r0 & 32'hFFFFFFFC) : (32'h00400800 + (($urandom % 4) << 2));
            if (($urandom % 2) == 0) begin
                m_lookup(upc, hit, tk, tg);
                upt = tk; uptg = tg;
            end else begin
                r1   = $urandom;
                upt  = 1'(($urandom % 2) == 0);
                uptg = r1 & 32'hFFFFFFFC;
            end
            drive(lv, lpc, ue, upc, uu, ut, utg, upt, uptg);

            if (lv) m_lookup(lpc, e_ph, e_pt, e_ptg);
            e_rv  = ue && ((ut != upt) || (ut && (utg != uptg)));
            e_rpc = ut ? utg : upc + 32'd8;
            if (ue) m_update(upc, uu, ut, utg);

            tick();
            chk("rnd_pred_valid", {31'h0, pred_valid}, {31'h0, lv});
            chk("rnd_pred_hit", {31'h0, pred_hit}, {31'h0, e_ph});
            chk("rnd_pred_taken", {31'h0, pred_taken}, {31'h0, e_pt});
            chk("rnd_pred_target", pred_target, e_ptg);
            chk("rnd_redirect_valid", {31'h0, redirect_valid}, {31'h0, e_rv});
            if (e_rv) chk("rnd_redirect_pc", redirect_pc, e_rpc);
        end

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
